// File: rtl/home_auto_pkg.sv
// home_auto_pkg: shared definitions for the home-automation arbiters.
//   disp_width     : display/state code width for n sensor channels
//   ev_heat/ev_cool: event indices of the heater and cooler services
//   code_to_onehot : display code -> one-hot service vector (MAX_EV wide)
package home_auto_pkg;

    localparam int MAX_SENSORS = 13;
    localparam int MAX_EV      = MAX_SENSORS + 2;

    // Codes 0 (idle), 1..n (sensors), n+1 (heater), n+2 (cooler).
    function automatic int disp_width(input int n);
        return $clog2(n + 3);
    endfunction

    function automatic int ev_heat(input int n);
        return n;
    endfunction

    function automatic int ev_cool(input int n);
        return n + 1;
    endfunction

    // Code k (1..n+2) lights bit k-1; idle or any out-of-range code gives zero.
    function automatic logic [MAX_EV-1:0] code_to_onehot(input int code, input int n);
        logic [MAX_EV-1:0] oh;
        if ((code >= 1) && (code <= n + 2)) begin
            oh    = '0;
            oh[0] = 1'b1;
            oh    = oh << (code - 1);
        end else begin
            oh = '0;
        end
        return oh;
    endfunction

endpackage

// File: rtl/home_event_arbiter_if.sv
// home_event_arbiter_if: sensor front-end <-> arbiter <-> actuator/display bundle.
//   sensors, ack, temp                 : driven by the front-end (master)
//   output_signals, display, pending   : driven by the arbiter (slave)
//   trans_cnt                          : only when TRANSITION_COUNT_EN is defined
interface home_event_arbiter_if #(
    parameter int NUM_SENSORS = 4,
    parameter int TEMP_W      = 6
);
    import home_auto_pkg::*;

    localparam int DW = disp_width(NUM_SENSORS);

    logic [NUM_SENSORS-1:0] sensors;
    logic [NUM_SENSORS-1:0] ack;
    logic [TEMP_W-1:0]      temp;
    logic [NUM_SENSORS+1:0] output_signals;
    logic [DW-1:0]          display;
    logic [NUM_SENSORS-1:0] pending;
`ifdef TRANSITION_COUNT_EN
    logic [15:0]            trans_cnt;

    modport master (output sensors, ack, temp,
                    input  output_signals, display, pending, trans_cnt);
    modport slave  (input  sensors, ack, temp,
                    output output_signals, display, pending, trans_cnt);
`else
    modport master (output sensors, ack, temp,
                    input  output_signals, display, pending);
    modport slave  (input  sensors, ack, temp,
                    output output_signals, display, pending);
`endif

endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational rotating-priority search.
//   req   : WIDTH request lines
//   start : index checked first; search wraps, so start-1 is checked last
//   valid : some request is set
//   grant : index of the first set request at or after start
module rr_priority_picker #(
    parameter  int WIDTH = 6,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    start,
    output logic             valid,
    output logic [IW-1:0]    grant
);

    logic [WIDTH-1:0] rot_s;
    int               off_s;

    // Rotate so the start position sits at bit 0; then it is a plain lowest-bit search.
    always_comb begin
        rot_s = WIDTH'({req, req} >> start);
    end

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        valid = 1'b0;
        off_s = 0;
        grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!valid && rot_s[i]) begin
                valid = 1'b1;
                off_s = i;
            end else begin
                valid = valid;
            end
        end
        if (int'(start) + off_s >= WIDTH) begin
            grant = IW'(int'(start) + off_s - WIDTH);
        end else begin
            grant = IW'(int'(start) + off_s);
        end
    end

endmodule

// File: rtl/home_event_arbiter.sv
// home_event_arbiter: picks one active service (sensor channel, heater, cooler
// or idle) with rotating priority, temperature hysteresis, minimum dwell and
// latched alarms cleared by acknowledge.
//   clk, rst             : clock, synchronous active-high reset
//   bus.sensors/ack/temp : inputs from the sensor front-end
//   bus.output_signals   : one-hot active service (sensors, heater, cooler)
//   bus.display          : state code (0 idle, i+1 sensor i, N+1 heater, N+2 cooler)
//   bus.pending          : latched-alarm flags
//   bus.trans_cnt        : saturating state-change count, only with TRANSITION_COUNT_EN
module home_event_arbiter
    import home_auto_pkg::*;
#(
    parameter int                     NUM_SENSORS = 4,
    parameter int                     TEMP_W      = 6,
    parameter int                     T_LOW       = 10,
    parameter int                     T_HIGH      = 21,
    parameter int                     HYST        = 2,
    parameter int                     MIN_DWELL   = 1,
    parameter logic [NUM_SENSORS-1:0] LATCH_MASK  = NUM_SENSORS'(4'b0100)
) (
    input  logic                 clk,
    input  logic                 rst,
    home_event_arbiter_if.slave  bus
);

    localparam int N       = NUM_SENSORS;
    localparam int NUM_EV  = N + 2;
    localparam int DW      = disp_width(N);
    localparam int IW      = $clog2(NUM_EV);
    localparam int DWELL_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    localparam int EVH     = ev_heat(N);
    localparam int EVC     = ev_cool(N);

    // Thresholds widened by one bit so T_LOW+HYST cannot wrap.
    localparam logic [TEMP_W:0] T_LOW_X       = (TEMP_W + 1)'(T_LOW);
    localparam logic [TEMP_W:0] HEAT_OFF_X    = (TEMP_W + 1)'(T_LOW + HYST);
    localparam logic [TEMP_W:0] T_HIGH_X      = (TEMP_W + 1)'(T_HIGH);
    localparam bit              COOL_HOLD_ALL = (T_HIGH < HYST);
    localparam logic [TEMP_W:0] COOL_OFF_X    = (TEMP_W + 1)'(COOL_HOLD_ALL ? 0 : T_HIGH - HYST);

    logic [DW-1:0]      state_r;
    logic [N+1:0]       out_r;
    logic [N-1:0]       pend_r;
    logic [DWELL_W-1:0] dwell_r;

    logic [DW-1:0]      state_nx_s;
    logic [N+1:0]       out_nx_s;
    logic [N-1:0]       pend_nx_s;
    logic [DWELL_W-1:0] dwell_nx_s;
    logic               changed_s;

    logic [TEMP_W:0]    temp_x_s;
    logic               heating_s;
    logic               cooling_s;
    logic               legal_s;
    logic [NUM_EV-1:0]  req_s;
    logic [IW-1:0]      start_s;
    logic               pick_valid_s;
    logic [IW-1:0]      pick_grant_s;
    logic [DW-1:0]      pick_code_s;

    // Request vector: sensors OR their latched alarms, plus heat/cool with hysteresis.
    always_comb begin
        temp_x_s   = {1'b0, bus.temp};
        heating_s  = (state_r == DW'(EVH + 1));
        cooling_s  = (state_r == DW'(EVC + 1));
        req_s      = '0;
        req_s[N-1:0] = bus.sensors | pend_r;
        req_s[EVH] = (temp_x_s < T_LOW_X) || (heating_s && (temp_x_s < HEAT_OFF_X));
        req_s[EVC] = (temp_x_s > T_HIGH_X) ||
                     (cooling_s && (COOL_HOLD_ALL || (temp_x_s > COOL_OFF_X)));
    end

    // Search start: code k (event k-1) starts at event k; idle and the last event start at 0.
    always_comb begin
        legal_s = (state_r <= DW'(NUM_EV));
        if (!legal_s || (state_r == DW'(NUM_EV))) begin
            start_s = '0;
        end else begin
            start_s = IW'(state_r);
        end
    end

    rr_priority_picker #(
        .WIDTH (NUM_EV)
    ) u_picker (
        .req   (req_s),
        .start (start_s),
        .valid (pick_valid_s),
        .grant (pick_grant_s)
    );

    // Next state with dwell hold; re-selecting the current state leaves the counter alone.
    always_comb begin
        state_nx_s = state_r;
        dwell_nx_s = dwell_r;
        changed_s  = 1'b0;
        if (pick_valid_s) begin
            pick_code_s = DW'(pick_grant_s) + DW'(1'b1);
        end else begin
            pick_code_s = '0;
        end
        if (!legal_s) begin
            state_nx_s = '0;
            dwell_nx_s = '0;
            changed_s  = 1'b1;
        end else if (dwell_r != '0) begin
            dwell_nx_s = dwell_r - DWELL_W'(1'b1);
        end else if (pick_code_s != state_r) begin
            state_nx_s = pick_code_s;
            dwell_nx_s = DWELL_W'(MIN_DWELL - 1);
            changed_s  = 1'b1;
        end else begin
            state_nx_s = state_r;
        end
        out_nx_s  = (N + 2)'(code_to_onehot(int'(state_nx_s), N));
        // Setting beats acknowledging; unmasked channels never latch.
        pend_nx_s = LATCH_MASK & (bus.sensors | (pend_r & ~bus.ack));
    end

    // State, one-hot outputs, alarms and dwell counter all move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= '0;
            out_r   <= '0;
            pend_r  <= '0;
            dwell_r <= '0;
        end else begin
            state_r <= state_nx_s;
            out_r   <= out_nx_s;
            pend_r  <= pend_nx_s;
            dwell_r <= dwell_nx_s;
        end
    end

    assign bus.display        = state_r;
    assign bus.output_signals = out_r;
    assign bus.pending        = pend_r;

`ifdef TRANSITION_COUNT_EN
    logic [15:0] trans_cnt_r;

    // Saturating count of real state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            trans_cnt_r <= 16'h0000;
        end else if (changed_s && (trans_cnt_r != 16'hFFFF)) begin
            trans_cnt_r <= trans_cnt_r + 16'h0001;
        end else begin
            trans_cnt_r <= trans_cnt_r;
        end
    end

    assign bus.trans_cnt = trans_cnt_r;
`endif

endmodule
